// File: rtl/arith_monitor.sv
// Result checker for a 3-cycle-latency arithmetic DUT: compares the DUT output with
// a behavioural expected value over a fixed-length run and captures the first mismatch.

module arith_monitor_exp #(
  parameter int WIDTH = 32,
  parameter int OP    = 0
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] exp_o
);
  // Context width is WIDTH, so carries, borrows and high product bits drop out.
  always_comb begin
    case (OP)
      1:       exp_o = a_i - b_i;
      2:       exp_o = a_i * b_i;
      default: exp_o = a_i + b_i;
    endcase
  end
endmodule

module arith_monitor #(
  parameter int WIDTH     = 32,
  parameter int OP        = 0,
  parameter int NUM_TESTS = 1024,
  parameter int WARMUP    = 8
) (
  input  logic             clk_dut,
  input  logic             reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_delayed_a,
  input  logic [WIDTH-1:0] i_delayed_b,
  input  logic [WIDTH-1:0] i_dut_out,
  input  logic [31:0]      i_dut_delay,
  input  logic             i_inject,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [31:0]      o_test_count,
  output logic [31:0]      o_err_count,
  output logic [WIDTH-1:0] o_first_err_a,
  output logic [WIDTH-1:0] o_first_err_b,
  output logic [WIDTH-1:0] o_first_err_out,
  output logic [WIDTH-1:0] o_first_err_exp
);
  localparam logic [31:0] DELAY_INVALID = 32'h0000FFFF;
  localparam logic [31:0] LAST_WARM     = 32'(WARMUP - 1);
  localparam logic [31:0] NUM_TESTS_W   = 32'(NUM_TESTS);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_WARMUP, S_RUN, S_DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] exp;
  } err_vec_t;

  state_t     state_q, state_d;
  logic [31:0] warm_q, warm_d;
  logic [31:0] test_q, test_d;
  logic [31:0] err_q, err_d;
  err_vec_t   first_q, first_d;
  logic [2:0] skip_q;
  logic [WIDTH-1:0] expected;
  logic       skip_3;

  arith_monitor_exp #(.WIDTH(WIDTH), .OP(OP)) u_exp (
    .a_i   (i_delayed_a),
    .b_i   (i_delayed_b),
    .exp_o (expected)
  );

  // Inject mask follows the driver's operand delay so it lines up with i_dut_out.
  assign skip_3 = skip_q[2];

  always_ff @(posedge clk_dut or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      warm_q  <= '0;
      test_q  <= '0;
      err_q   <= '0;
      first_q <= '0;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      test_q  <= test_d;
      err_q   <= err_d;
      first_q <= first_d;
      skip_q  <= {skip_q[1:0], i_inject};
    end
  end

  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    test_d  = test_q;
    err_d   = err_q;
    first_d = first_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_d = S_ARM;
          test_d  = '0;
          err_d   = '0;
          first_d = '0;
        end
      end
      S_ARM: begin
        if (i_dut_delay != DELAY_INVALID) begin
          state_d = (WARMUP == 0) ? S_RUN : S_WARMUP;
          warm_d  = '0;
        end
      end
      S_WARMUP: begin
        if (warm_q == LAST_WARM) state_d = S_RUN;
        else                     warm_d  = warm_q + 32'd1;
      end
      S_RUN: begin
        if (!skip_3) begin
          test_d = test_q + 32'd1;
          if (i_dut_out != expected) begin
            err_d = (err_q == '1) ? err_q : err_q + 32'd1;
            if (err_q == '0) first_d = '{a: i_delayed_a, b: i_delayed_b,
                                         out: i_dut_out, exp: expected};
          end
          if (test_d == NUM_TESTS_W) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_busy          = (state_q == S_ARM) || (state_q == S_WARMUP) || (state_q == S_RUN);
  assign o_done          = (state_q == S_DONE);
  assign o_pass          = (state_q == S_DONE) && (err_q == '0);
  assign o_test_count    = test_q;
  assign o_err_count     = err_q;
  assign o_first_err_a   = first_q.a;
  assign o_first_err_b   = first_q.b;
  assign o_first_err_out = first_q.out;
  assign o_first_err_exp = first_q.exp;
endmodule
